// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// PllResetSequencer (pll_reset_sequencer)
//
// Supervises the system PLL from the free-running board reference clock.
// It pulses the PLL reset and waits for a qualified lock. Once lock has been
// stable for long enough, it releases the downstream resets in a fixed order:
// fabric, then memory controller, then CPU. Any later lock loss reasserts
// every reset at once and restarts the sequence.
//
// Ports:
//   clk            50 MHz reference clock (same source as the PLL reference)
//   rst            asynchronous active-high reset
//   pll_locked_in  PLL locked flag, asynchronous to clk
//   sw_reset_req   single-cycle request to re-run the whole sequence
//   pll_rst_out    PLL reset, active-high
//   sys_rst_out    fabric/interconnect reset, active-high
//   mem_rst_out    SDRAM controller reset, active-high
//   cpu_rst_out    CPU reset, active-high
//   ready          high only while every reset is released
//   loss_count     saturating count of lock losses after release began
//   timeout_count  saturating count of lock timeouts
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 256,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked_in,
    input  logic             sw_reset_req,
    output logic             pll_rst_out,
    output logic             sys_rst_out,
    output logic             mem_rst_out,
    output logic             cpu_rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    // The shared cycle counter only has to reach the longest dwell minus one.
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int MAX_D  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAGE_LAST   = TMR_W'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        REL_SYS,
        REL_MEM,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [TMR_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic                   loss_evt;
    logic                   timeout_evt;

    // Bring the asynchronous locked flag into the clk domain. Nothing else in
    // the block looks at the raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_in};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Next-state decision. In the release states a lock loss wins over a
    // software request, so a coincident request still counts as one loss.
    // A dropout while still qualifying lock only sends us back to wait.
    always_comb begin
        state_nx    = state;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            PLL_RESET: begin
                if (cnt == PLL_RST_LAST) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (sw_reset_req) begin
                    state_nx = PLL_RESET;
                end else if (lock_s) begin
                    state_nx = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_evt = 1'b1;
                    state_nx    = PLL_RESET;
                end
            end
            STABLE: begin
                if (sw_reset_req)              state_nx = PLL_RESET;
                else if (!lock_s)              state_nx = WAIT_LOCK;
                else if (cnt == STABLE_LAST)   state_nx = REL_SYS;
            end
            REL_SYS: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_nx = PLL_RESET;
                end else if (sw_reset_req) begin
                    state_nx = PLL_RESET;
                end else if (cnt == STAGE_LAST) begin
                    state_nx = REL_MEM;
                end
            end
            REL_MEM: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_nx = PLL_RESET;
                end else if (sw_reset_req) begin
                    state_nx = PLL_RESET;
                end else if (cnt == STAGE_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_nx = PLL_RESET;
                end else if (sw_reset_req) begin
                    state_nx = PLL_RESET;
                end
            end
            default: state_nx = PLL_RESET;
        endcase
    end

    // State, dwell counter, event counters and outputs. Outputs are decoded
    // from the next state so they move on the same edge as the state does;
    // reassertion is therefore simultaneous for every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PLL_RESET;
            cnt           <= '0;
            pll_rst_out   <= 1'b1;
            sys_rst_out   <= 1'b1;
            mem_rst_out   <= 1'b1;
            cpu_rst_out   <= 1'b1;
            ready         <= 1'b0;
            loss_count    <= '0;
            timeout_count <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (state != RUN) begin
                cnt <= cnt + TMR_W'(1);
            end
            pll_rst_out <= (state_nx == PLL_RESET);
            sys_rst_out <= (state_nx == PLL_RESET) || (state_nx == WAIT_LOCK) || (state_nx == STABLE);
            mem_rst_out <= !((state_nx == REL_MEM) || (state_nx == RUN));
            cpu_rst_out <= (state_nx != RUN);
            ready       <= (state_nx == RUN);
            if (loss_evt && (loss_count != '1)) begin
                loss_count <= loss_count + CNT_W'(1);
            end
            if (timeout_evt && (timeout_count != '1)) begin
                timeout_count <= timeout_count + CNT_W'(1);
            end
        end
    end

endmodule
